ahb_memory_slave: RTL and testbench
===================================

# ahb_memory_slave

AHB-Lite subordinate with word-addressed storage, placed on each `ahbSlaveInterface[s]` port behind the interconnect. It answers the interconnect's forwarded address/data phases with `hreadyout`, `hresp` and `hrdata`. It supports a programmable wait-state count and returns two-cycle ERROR responses for illegal accesses. It is the responder end of the bus the interconnect initiates on.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (32 or 64)
- MEM_DEPTH, 1024, number of DATA_WIDTH words
- LOCAL_ADDR_BITS, 16, low haddr bits used as local byte offset (upper bits belong to the interconnect decoder)
- WAIT_STATES, 0, wait cycles (hreadyout low) inserted before every OKAY data phase; range 0–15
- Clocking: one clock `hclk`; reset `hreset` is synchronous and active-high.
- hclk  in  1  bus clock
- hreset  in  1  synchronous reset, active-high
- hselx  in  1  slave select from interconnect
- haddr  in  ADDR_WIDTH  address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write
- hsize  in  3  transfer size, bytes = 2**hsize
- hburst  in  3  burst type (accepted, not checked)
- hprot  in  4  protection (ignored)
- hmastlock  in  1  locked transfer (ignored, no effect)
- hready  in  1  bus-level ready (combined), qualifies address phase
- hwdata  in  DATA_WIDTH  write data, valid in data phase
- hreadyout  out  1  slave ready
- hresp  out  2  OKAY=00, ERROR=01
- hrdata  out  DATA_WIDTH  read data

## Operation
- Address phase accepted on a rising edge when hselx & hready & htrans[1]. The block registers addr, size, write and an error flag into the data-phase registers.
- IDLE/BUSY, or hselx=0, with hready=1: nothing is registered. The next cycle is a zero-wait OKAY.
- Error conditions are evaluated at acceptance:
  - size: hsize > log2(DATA_WIDTH/8)
  - alignment: haddr & (2**hsize−1) ≠ 0
  - range: haddr[LOCAL_ADDR_BITS−1:0] ≥ MEM_DEPTH·DATA_WIDTH/8
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=OKAY. On acceptance: error → ERR1; WAIT_STATES=0 → LAST; otherwise → WAIT with counter loaded to WAIT_STATES−1.
  - WAIT: hreadyout=0, hresp=OKAY. Counter decrements each cycle; at 0 → LAST.
  - LAST: hreadyout=1, hresp=OKAY.
    - Write: bytes are committed on the closing edge, byte enables from size and addr low bits, little-endian.
    - Read: hrdata = mem[word index].
    - A pipelined acceptance in the same cycle follows the IDLE rules; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=ERROR, no storage access → ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. Acceptance follows the IDLE rules, so a non-cancelled next transfer is taken.
- hrdata is 0 except in LAST of a read. Narrow reads return the full word; the master selects the lane.
- Storage is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: hreadyout=1, hresp=00, hrdata=0, FSM=IDLE, counter=0. Any in-flight transfer is dropped and no write commits on the reset edge.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles. ERROR data phase lasts exactly 2 cycles.
- Back-to-back NONSEQ/SEQ at WAIT_STATES=0: one transfer per cycle, hreadyout stays 1.
- Write then read to the same address in consecutive cycles returns the new data: the write commits at the end of LAST and the read is served in the following data phase.
- No address sampling while hreadyout=0, because hready is low.
- hwdata is sampled only on the LAST closing edge.

## Structure
- AhbGlobalPackage gains:
  - htrans enum (IDLE/BUSY/NONSEQ/SEQ)
  - hresp enum (OKAY/ERROR)
  - hsize enum
  - slave FSM state enum
  - a byte-enable function (size, addr_lsb, DATA_WIDTH) → strobe
- One sub-module, `ahb_slave_mem`: MEM_DEPTH×DATA_WIDTH array with byte-strobe synchronous write and asynchronous read.
- Top block holds the FSM, wait counter, data-phase registers and error check.

## Test plan
- Reset then idle: hreset=1 for 2 cycles → hreadyout=1, hresp=00, hrdata=0; IDLE htrans with hselx=1 → stays OKAY.
- WAIT_STATES=0:
  - stimulus: word write 0x0000_0010 ← 0xDEADBEEF, then read 0x10 in the next cycle
  - response: read data phase hrdata=0xDEADBEEF; hreadyout never low
- WAIT_STATES=3:
  - stimulus: NONSEQ read
  - response: hreadyout low exactly 3 cycles, then high with data; no second address sampled during the wait
- Byte write:
  - stimulus: hsize=0, addr 0x13, data 0xAB000000 onto word 0x11223344
  - response: read of 0x10 returns 0xAB223344
- Errors:
  - stimulus: halfword at 0x01; addr 0x1000 with MEM_DEPTH=1024; hsize=3 on a 32-bit bus
  - response: each gives hreadyout 0→1 with hresp=01 both cycles, and memory is unchanged
- Reset mid-WAIT:
  - stimulus: hreset asserted during a write's WAIT state
  - response: outputs return to reset values next cycle; the target word is unchanged

Source files
------------

// File: rtl/ahb_memory_slave_pkg.sv
// Shared AHB-Lite encodings, the subordinate FSM state type and the byte-strobe helper
// used by the memory subordinate.
package ahb_memory_slave_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

   // Little-endian lane strobe for a legal (size, offset) pair, clipped to the bus width.
   function automatic logic [7:0] byte_strobe(input logic [2:0] size,
                                              input logic [2:0] addr_lsb,
                                              input int unsigned bytes);
      logic [15:0] nbytes;
      logic [15:0] mask;
      nbytes = 16'd1 << size;
      mask   = ((16'd1 << nbytes) - 16'd1) << addr_lsb;
      return 8'(mask & ((16'd1 << bytes) - 16'd1));
   endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word array with byte-strobed synchronous write and asynchronous read.
module ahb_slave_mem
   import ahb_memory_slave_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
   input  logic                    hclk,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] strb,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge hclk) begin
      if (we) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/ahb_memory_slave.sv
// AHB-Lite memory subordinate: address-phase capture, legality check, wait-state FSM
// and the data-phase response in front of the word array.
module ahb_memory_slave
   import ahb_memory_slave_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MEM_DEPTH       = 1024,
   parameter int LOCAL_ADDR_BITS = 16,
   parameter int WAIT_STATES     = 0
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  hselx,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic                  hmastlock,
   input  logic                  hready,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [DATA_WIDTH-1:0] hrdata
);

   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int SIZE_MAX  = $clog2(BYTES);
   localparam int OFS_W     = $clog2(BYTES);
   localparam int IDX_W     = $clog2(MEM_DEPTH);
   localparam int MEM_BYTES = MEM_DEPTH * BYTES;
   localparam logic [LOCAL_ADDR_BITS:0] MEM_BYTES_L = (LOCAL_ADDR_BITS+1)'(MEM_BYTES);

   slv_state_e                 state;
   logic [3:0]                 cnt;
   logic [LOCAL_ADDR_BITS-1:0] dp_addr;
   logic [2:0]                 dp_size;
   logic                       dp_write;

   logic       accept, req_err, size_err, align_err, range_err;
   logic [7:0] align_mask;
   slv_state_e acc_state;
   logic       acc_ready;
   hresp_e     acc_resp;
   logic [3:0] acc_cnt;

   logic                  mem_we;
   logic [BYTES-1:0]      mem_strb;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign accept     = hselx & hready & htrans[1];
   assign align_mask = (8'd1 << hsize) - 8'd1;
   assign size_err   = hsize > 3'(SIZE_MAX);
   assign align_err  = |(haddr[7:0] & align_mask);
   assign range_err  = {1'b0, haddr[LOCAL_ADDR_BITS-1:0]} >= MEM_BYTES_L;
   assign req_err    = size_err | align_err | range_err;

   // Where a freshly accepted transfer lands; shared by IDLE, LAST and ERR2.
   always_comb begin
      acc_state = ST_LAST;
      acc_ready = 1'b1;
      acc_resp  = HRESP_OKAY;
      acc_cnt   = '0;
      if (req_err) begin
         acc_state = ST_ERR1;
         acc_ready = 1'b0;
         acc_resp  = HRESP_ERROR;
      end else if (WAIT_STATES != 0) begin
         acc_state = ST_WAIT;
         acc_ready = 1'b0;
         acc_cnt   = 4'(WAIT_STATES - 1);
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
         dp_addr   <= '0;
         dp_size   <= '0;
         dp_write  <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (cnt == '0) begin
                  state     <= ST_LAST;
                  hreadyout <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               hreadyout <= 1'b1;
            end
            default: begin
               if (accept) begin
                  state     <= acc_state;
                  hreadyout <= acc_ready;
                  hresp     <= acc_resp;
                  cnt       <= acc_cnt;
                  dp_addr   <= haddr[LOCAL_ADDR_BITS-1:0];
                  dp_size   <= hsize;
                  dp_write  <= hwrite;
               end else begin
                  state     <= ST_IDLE;
                  hreadyout <= 1'b1;
                  hresp     <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   // Writes commit on the edge that closes LAST; a reset on that edge wins.
   assign mem_we   = (state == ST_LAST) & dp_write & ~hreset;
   assign mem_strb = BYTES'(byte_strobe(dp_size, 3'(dp_addr[OFS_W-1:0]), BYTES));
   assign hrdata   = (state == ST_LAST && !dp_write) ? mem_rdata : '0;

   ahb_slave_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .hclk  (hclk),
      .we    (mem_we),
      .strb  (mem_strb),
      .idx   (dp_addr[OFS_W +: IDX_W]),
      .wdata (hwdata),
      .rdata (mem_rdata)
   );

   logic unused_in;
   assign unused_in = ^{hburst, hprot, hmastlock, htrans[0], haddr[ADDR_WIDTH-1:LOCAL_ADDR_BITS]};

endmodule

// File: tb/tb_ahb_memory_slave.sv
// Directed bench: a zero-wait and a three-wait instance share the request bus; each
// sees its own hreadyout as the bus-level hready.
module tb_ahb_memory_slave;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel0 = 1'b0, hsel3 = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd2;
   logic [31:0] hwdata = '0;
   logic        hready0, hready3, hreadyout0, hreadyout3;
   logic [1:0]  hresp0, hresp3;
   logic [31:0] hrdata0, hrdata3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 hclk = ~hclk;

   assign hready0 = hreadyout0;
   assign hready3 = hreadyout3;

   ahb_memory_slave #(.WAIT_STATES(0)) dut0 (
      .hclk(hclk), .hreset(hreset), .hselx(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
      .hready(hready0), .hwdata(hwdata), .hreadyout(hreadyout0), .hresp(hresp0),
      .hrdata(hrdata0));

   ahb_memory_slave #(.WAIT_STATES(3)) dut3 (
      .hclk(hclk), .hreset(hreset), .hselx(hsel3), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
      .hready(hready3), .hwdata(hwdata), .hreadyout(hreadyout3), .hresp(hresp3),
      .hrdata(hrdata3));

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
      haddr  = a;
      hwrite = wr;
      hsize  = sz;
      htrans = 2'b10;
   endtask

   // Advance through dut3's wait cycles, bounded; returns the number of low cycles seen.
   task automatic wait_done3(output int lows);
      lows = 0;
      while (hreadyout3 !== 1'b1 && lows < 20) begin
         lows++;
         step();
      end
   endtask

   task automatic test_reset();
      hreset = 1'b1;
      step(); step();
      n_checks++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL rst_ready0 got %b exp 1", hreadyout0); end
      n_checks++; if (hresp0 !== 2'b00) begin n_fail++; $display("FAIL rst_resp0 got %b exp 00", hresp0); end
      n_checks++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata0 got %h exp 0", hrdata0); end
      n_checks++; if (hreadyout3 !== 1'b1) begin n_fail++; $display("FAIL rst_ready3 got %b exp 1", hreadyout3); end
      n_checks++; if (hresp3 !== 2'b00) begin n_fail++; $display("FAIL rst_resp3 got %b exp 00", hresp3); end
      hreset = 1'b0;
      hsel0  = 1'b1;
      htrans = 2'b00;
      step();
      n_checks++; if (hreadyout0 !== 1'b1 || hresp0 !== 2'b00) begin n_fail++; $display("FAIL idle_okay got %b/%b exp 1/00", hreadyout0, hresp0); end
      htrans = 2'b01;
      step();
      n_checks++; if (hreadyout0 !== 1'b1 || hresp0 !== 2'b00) begin n_fail++; $display("FAIL busy_okay got %b/%b exp 1/00", hreadyout0, hresp0); end
      htrans = 2'b00;
   endtask

   task automatic test_write_read();
      hsel0 = 1'b1;
      addr_phase(32'h10, 1'b1, 3'd2);
      step();
      n_checks++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL wr_ready got %b exp 1", hreadyout0); end
      hwdata = 32'hDEADBEEF;
      addr_phase(32'h10, 1'b0, 3'd2);
      step();
      n_checks++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL rd_ready got %b exp 1", hreadyout0); end
      n_checks++; if (hrdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got %h exp deadbeef", hrdata0); end
      htrans = 2'b00;
      step();
      n_checks++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL rd_idle_data got %h exp 0", hrdata0); end
   endtask

   task automatic test_byte_write();
      hsel0 = 1'b1;
      addr_phase(32'h10, 1'b1, 3'd2);
      step();
      hwdata = 32'h11223344;
      addr_phase(32'h13, 1'b1, 3'd0);
      step();
      n_checks++; if (hreadyout0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", hreadyout0); end
      hwdata = 32'hAB000000;
      addr_phase(32'h10, 1'b0, 3'd2);
      step();
      n_checks++; if (hrdata0 !== 32'hAB223344) begin n_fail++; $display("FAIL byte_wr_data got %h exp ab223344", hrdata0); end
      addr_phase(32'h12, 1'b1, 3'd1);
      step();
      hwdata = 32'h5A5A0000;
      addr_phase(32'h10, 1'b0, 3'd0);
      step();
      n_checks++; if (hrdata0 !== 32'h5A5A3344) begin n_fail++; $display("FAIL half_wr_data got %h exp 5a5a3344", hrdata0); end
      htrans = 2'b00;
      step();
   endtask

   task automatic test_errors();
      logic [31:0] ea [3];
      logic [2:0]  es [3];
      ea[0] = 32'h11;   es[0] = 3'd1;
      ea[1] = 32'h1000; es[1] = 3'd2;
      ea[2] = 32'h10;   es[2] = 3'd3;
      hsel0  = 1'b1;
      hwdata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         addr_phase(ea[i], 1'b1, es[i]);
         step();
         htrans = 2'b00;
         n_checks++; if (hreadyout0 !== 1'b0 || hresp0 !== 2'b01) begin n_fail++; $display("FAIL err%0d_c1 got %b/%b exp 0/01", i, hreadyout0, hresp0); end
         step();
         n_checks++; if (hreadyout0 !== 1'b1 || hresp0 !== 2'b01) begin n_fail++; $display("FAIL err%0d_c2 got %b/%b exp 1/01", i, hreadyout0, hresp0); end
         step();
         n_checks++; if (hreadyout0 !== 1'b1 || hresp0 !== 2'b00) begin n_fail++; $display("FAIL err%0d_after got %b/%b exp 1/00", i, hreadyout0, hresp0); end
      end
      addr_phase(32'h10, 1'b0, 3'd2);
      step();
      htrans = 2'b00;
      n_checks++; if (hrdata0 !== 32'h5A5A3344) begin n_fail++; $display("FAIL err_mem_kept got %h exp 5a5a3344", hrdata0); end
      step();
      hsel0 = 1'b0;
   endtask

   task automatic test_wait_states();
      int lows;
      hsel3 = 1'b1;
      addr_phase(32'h20, 1'b1, 3'd2);
      step();
      hwdata = 32'hCAFEF00D;
      htrans = 2'b00;
      wait_done3(lows);
      n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL ws_wr_lows got %0d exp 3", lows); end
      addr_phase(32'h20, 1'b0, 3'd2);
      step();
      n_checks++; if (hrdata3 !== 32'h0) begin n_fail++; $display("FAIL ws_rd_wait_data got %h exp 0", hrdata3); end
      addr_phase(32'h24, 1'b1, 3'd2);
      wait_done3(lows);
      n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL ws_rd_lows got %0d exp 3", lows); end
      n_checks++; if (hrdata3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL ws_rd_data got %h exp cafef00d", hrdata3); end
      htrans = 2'b00;
      step();
      n_checks++; if (hreadyout3 !== 1'b1 || hrdata3 !== 32'h0) begin n_fail++; $display("FAIL ws_no_extra got %b/%h exp 1/0", hreadyout3, hrdata3); end
   endtask

   task automatic test_reset_mid_wait();
      int lows;
      hsel3 = 1'b1;
      addr_phase(32'h20, 1'b1, 3'd2);
      step();
      hwdata = 32'h5555AAAA;
      htrans = 2'b00;
      step();
      n_checks++; if (hreadyout3 !== 1'b0) begin n_fail++; $display("FAIL mid_wait_low got %b exp 0", hreadyout3); end
      hreset = 1'b1;
      step();
      hreset = 1'b0;
      n_checks++; if (hreadyout3 !== 1'b1 || hresp3 !== 2'b00 || hrdata3 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_outs got %b/%b/%h exp 1/00/0", hreadyout3, hresp3, hrdata3); end
      step();
      addr_phase(32'h20, 1'b0, 3'd2);
      step();
      htrans = 2'b00;
      wait_done3(lows);
      n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL mid_rd_lows got %0d exp 3", lows); end
      n_checks++; if (hrdata3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_rst_kept got %h exp cafef00d", hrdata3); end
      step();
      hsel3 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_write();
      test_errors();
      test_wait_states();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
